// File: rtl/irq_pkg.sv
// irq_pkg: shared FSM state type and limits for the external interrupt controller
package irq_pkg;
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} irq_state_t;
    localparam int N_SRC_MAX = 16;
endpackage

// File: rtl/prio_enc.sv
// prio_enc: lowest-index-wins priority encoder
module prio_enc #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] sel_o,
    output logic         any_o
);
    always_comb begin
        sel_o = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req_i[i]) sel_o = W'(i);
    end
    assign any_o = |req_i;
endmodule

// File: rtl/irq_controller.sv
// irq_controller: edge-latched, masked, lowest-index-priority ExtIRQ/ExtIAck/ERet handshake
module irq_controller
    import irq_pkg::*;
#(
    parameter int               N_SRC      = 4,
    parameter logic [N_SRC-1:0] MASK_RESET = '1,
    localparam int              ID_W       = $clog2(N_SRC)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_SRC-1:0] irq_src_i,
    input  logic             mask_we_i,
    input  logic [N_SRC-1:0] mask_wdata_i,
    input  logic             ext_iack_i,
    input  logic             eret_i,
    output logic             ext_irq_o,
    output logic [ID_W-1:0]  irq_id_o,
    output logic             irq_active_o,
    output logic [N_SRC-1:0] irq_pending_o,
    output logic [N_SRC-1:0] irq_mask_o
);
    irq_state_t       state_q, state_d;
    logic [N_SRC-1:0] pending_q, pending_d, src_prev_q, mask_q, mask_d, clr, eligible;
    logic [ID_W-1:0]  id_q, id_d, sel;
    logic             any;

    assign eligible = pending_q & mask_q;

    prio_enc #(.N(N_SRC)) u_enc (
        .req_i(eligible),
        .sel_o(sel),
        .any_o(any)
    );

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        clr     = '0;
        case (state_q)
            IDLE: begin
                if (any) begin
                    state_d = REQ;
                    id_d    = sel;
                end
            end
            // ERet coincident with the ack is deliberately ignored here
            REQ: begin
                if (ext_iack_i) begin
                    clr     = {{(N_SRC-1){1'b0}}, 1'b1} << id_q;
                    state_d = SERVICE;
                end
            end
            SERVICE: state_d = eret_i ? IDLE : SERVICE;
            default: state_d = IDLE;
        endcase
    end

    // a new rising edge beats the ack clear on the same bit
    assign pending_d = (pending_q & ~clr) | (irq_src_i & ~src_prev_q);
    assign mask_d    = mask_we_i ? mask_wdata_i : mask_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            src_prev_q <= '0;
            mask_q     <= MASK_RESET;
            id_q       <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            src_prev_q <= irq_src_i;
            mask_q     <= mask_d;
            id_q       <= id_d;
        end
    end

    assign ext_irq_o     = state_q == REQ;
    assign irq_active_o  = state_q != IDLE;
    assign irq_id_o      = id_q;
    assign irq_pending_o = pending_q;
    assign irq_mask_o    = mask_q;
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed plus random stimulus against a behavioural interrupt model
module tb_irq_controller;
    logic       clk, rst_n, mask_we, ack, eret;
    logic [3:0] src, wdata;
    logic       ext_irq, active;
    logic [1:0] id;
    logic [3:0] pending, mask;
    int         checks = 0;
    int         failures = 0;

    bit [3:0] m_pend, m_prev, m_mask;
    bit       m_req, m_svc;
    int       m_id;

    irq_controller dut (
        .clk_i(clk), .rst_ni(rst_n), .irq_src_i(src), .mask_we_i(mask_we),
        .mask_wdata_i(wdata), .ext_iack_i(ack), .eret_i(eret), .ext_irq_o(ext_irq),
        .irq_id_o(id), .irq_active_o(active), .irq_pending_o(pending), .irq_mask_o(mask)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_prev = 0; m_mask = 4'hf; m_req = 0; m_svc = 0; m_id = 0;
    endtask

    // one clock of the controller's rules, from the inputs about to be sampled
    task automatic model_step();
        bit [3:0] elig, iso, clr;
        bit nreq, nsvc;
        clr = 0; nreq = m_req; nsvc = m_svc;
        if (!m_req && !m_svc) begin
            elig = m_pend & m_mask;
            if (elig != 0) begin
                iso  = elig & (~elig + 4'd1);
                m_id = $clog2(iso);
                nreq = 1;
            end
        end else if (m_req) begin
            if (ack) begin
                clr[m_id] = 1'b1;
                nreq = 0;
                nsvc = 1;
            end
        end else if (eret) nsvc = 0;
        m_pend = (m_pend & ~clr) | (src & ~m_prev);
        m_prev = src;
        if (mask_we) m_mask = wdata;
        m_req = nreq;
        m_svc = nsvc;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".irq"}, 32'(ext_irq), 32'(m_req));
        chk({tag, ".active"}, 32'(active), 32'(m_req | m_svc));
        chk({tag, ".pending"}, 32'(pending), 32'(m_pend));
        chk({tag, ".mask"}, 32'(mask), 32'(m_mask));
        chk({tag, ".id"}, 32'(id), m_id);
    endtask

    task automatic step(input string tag, input logic [3:0] s, input logic a, input logic e,
                        input logic we, input logic [3:0] wd);
        src = s; ack = a; eret = e; mask_we = we; wdata = wd;
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n = 0; src = 0; ack = 0; eret = 0; mask_we = 0; wdata = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset.mask_ones", 32'(mask), 32'hf);
        rst_n = 1;

        step("pulse2", 4'b0100, 0, 0, 0, 0);
        chk("pulse2.pend", 32'(pending), 32'b0100);
        chk("pulse2.noirq", 32'(ext_irq), 0);
        step("req2", 4'b0000, 0, 0, 0, 0);
        chk("req2.irq", 32'(ext_irq), 1);
        chk("req2.id", 32'(id), 2);
        step("ack2", 4'b0000, 1, 0, 0, 0);
        chk("ack2.irq", 32'(ext_irq), 0);
        chk("ack2.active", 32'(active), 1);
        chk("ack2.pend", 32'(pending), 0);
        step("eret2", 4'b0000, 0, 1, 0, 0);
        chk("eret2.active", 32'(active), 0);

        step("pri.rise", 4'b1010, 0, 0, 0, 0);
        step("pri.req", 4'b0000, 0, 0, 0, 0);
        chk("pri.id1", 32'(id), 1);
        step("pri.ack", 4'b0000, 1, 1, 0, 0);
        chk("pri.ack_wins", 32'(active), 1);
        step("pri.eret", 4'b0000, 0, 1, 0, 0);
        chk("pri.idle", 32'(active), 0);
        step("pri.req3", 4'b0000, 0, 0, 0, 0);
        chk("pri.id3", 32'(id), 3);
        chk("pri.irq3", 32'(ext_irq), 1);
        step("pri.ack3", 4'b0000, 1, 0, 0, 0);
        step("pri.eret3", 4'b0000, 0, 1, 0, 0);

        step("mask.wr", 4'b0001, 0, 0, 1, 4'b1110);
        chk("mask.pend0", 32'(pending), 32'b0001);
        step("mask.hold", 4'b0000, 0, 0, 0, 0);
        chk("mask.noirq", 32'(ext_irq), 0);
        step("mask.open", 4'b0000, 0, 0, 1, 4'b1111);
        chk("mask.stillidle", 32'(ext_irq), 0);
        step("mask.req", 4'b0000, 0, 0, 0, 0);
        chk("mask.irq", 32'(ext_irq), 1);
        chk("mask.id0", 32'(id), 0);
        step("mask.retract", 4'b0000, 0, 0, 1, 4'b1110);
        chk("mask.noretract", 32'(ext_irq), 1);
        step("mask.ack", 4'b0000, 1, 0, 1, 4'b1111);
        step("mask.eret", 4'b0000, 0, 1, 0, 0);

        step("sc.rise", 4'b0100, 0, 0, 0, 0);
        step("sc.req", 4'b0000, 0, 0, 0, 0);
        step("sc.ack", 4'b0100, 1, 0, 0, 0);
        chk("sc.pend_kept", 32'(pending), 32'b0100);
        step("sc.held", 4'b0100, 0, 1, 0, 0);
        step("sc.req2", 4'b0000, 0, 0, 0, 0);
        chk("sc.id2", 32'(id), 2);
        chk("sc.irq", 32'(ext_irq), 1);
        step("sc.ack2", 4'b0000, 1, 0, 0, 0);
        step("sc.eret2", 4'b0000, 0, 1, 0, 0);

        step("stray.ack", 4'b0000, 1, 0, 0, 0);
        chk("stray.ack_idle", 32'(active), 0);
        step("stray.eret", 4'b0000, 0, 1, 0, 0);
        chk("stray.eret_idle", 32'(active), 0);

        step("ar.rise", 4'b0001, 0, 0, 0, 0);
        step("ar.req", 4'b0000, 0, 0, 0, 0);
        step("ar.ack", 4'b1000, 1, 0, 0, 0);
        chk("ar.svc", 32'(active), 1);
        chk("ar.pend3", 32'(pending), 32'b1000);
        #2 rst_n = 0;
        #1;
        model_reset();
        chk("ar.irq", 32'(ext_irq), 0);
        chk("ar.active", 32'(active), 0);
        chk("ar.pend", 32'(pending), 0);
        src = 0;
        #2 rst_n = 1;
        @(posedge clk);
        #1;
        model_step();
        check_all("ar.release");

        for (int i = 0; i < 400; i++)
            step("rand", 4'($urandom_range(0, 15)), $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, 4'($urandom_range(0, 15)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- External interrupt controller that drives the processor's ExtIRQ/ExtIAck handshake.
- Latches rising edges on N device interrupt lines and applies a software-writable enable mask.
- Picks the highest-priority enabled pending source, raises ExtIRQ and holds it until ExtIAck.
- Stays in service, holding the granted ID stable for the handler, until the processor commits ERet.

Parameters:
N_SRC, 4, number of interrupt source lines (2..16)
MASK_RESET, all ones (N_SRC bits), value loaded into the enable mask at reset
ID_W, $clog2(N_SRC), localparam: width of irq_id

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
irq_src  in  N_SRC  device interrupt lines, synchronous to clk, level
mask_we  in  1  write strobe for the enable mask
mask_wdata  in  N_SRC  new enable mask (1 = enabled)
ExtIAck  in  1  processor acknowledge, one-cycle pulse
ERet  in  1  processor committed exception return, one-cycle pulse
ExtIRQ  out  1  interrupt request to the processor
irq_id  out  ID_W  index of the granted source, valid while irq_active
irq_active  out  1  a request is outstanding or in service
irq_pending  out  N_SRC  pending register, readable by software
irq_mask  out  N_SRC  current enable mask

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE; pending=0; src_prev=0; mask=MASK_RESET; irq_id=0; ExtIRQ=0; irq_active=0.
- Edge detect: src_prev<=irq_src every cycle. rise = irq_src & ~src_prev. pending <= (pending & ~clr) | rise. A set on the same bit wins over clr in the same cycle.
- Mask: if mask_we, mask<=mask_wdata at the next edge. Masking never clears pending bits. eligible = pending & mask, using registered values.
- Priority: lowest index wins. sel = index of lowest set bit of eligible.
- FSM (registered state; ExtIRQ = state==REQ; irq_active = state!=IDLE; all glitch-free decodes):
  - IDLE: if eligible!=0, irq_id<=sel and go to REQ. Otherwise stay.
  - REQ: ExtIRQ=1; irq_id frozen. On ExtIAck: clr=onehot(irq_id), go to SERVICE. ExtIRQ deasserts the cycle after the ack edge. Clearing the mask bit of irq_id while in REQ does not retract the request.
  - SERVICE: ExtIRQ=0; irq_id frozen. On ERet, go to IDLE. New edges keep accumulating in pending.
- Latency: irq_src rises, sampled at edge k → pending set at edge k → REQ at edge k+1 → ExtIRQ high from edge k+1. If eligible at ERet, IDLE lasts exactly one cycle before the next REQ.
- Ignored events: ExtIAck outside REQ, ERet outside SERVICE, and ERet coincident with ExtIAck in REQ (only the ack is taken).
- Held level: a source still high after ack does not re-pend; it needs a new rising edge.
- No nesting: one request in flight at a time.
- Reset mid-REQ or mid-SERVICE: immediate return to the reset values above, ExtIRQ=0 asynchronously.

Decomposition:
- Shared package irq_pkg:
  - typedef enum logic [1:0] {IDLE, REQ, SERVICE} irq_state_t
  - constant N_SRC_MAX=16
- One natural sub-module, prio_enc: parameterised lowest-index priority encoder (eligible → sel, any).

Test Plan:
- Reset and default: reset=0 then 1; pulse irq_src[2] for 1 cycle → pending=4'b0100 next edge, ExtIRQ=1 one edge later, irq_id=2.
- Full handshake: in REQ assert ExtIAck 1 cycle → ExtIRQ=0 next cycle, pending[2]=0, irq_active=1. Pulse ERet → irq_active=0, state IDLE.
- Priority: rise irq_src[3] and irq_src[1] on the same cycle → irq_id=1. After ack+ERet, irq_id=3 with exactly one IDLE cycle in between.
- Mask: write mask_wdata=4'b1110, rise irq_src[0] → pending[0]=1, ExtIRQ stays 0. Write mask=4'b1111 → ExtIRQ=1 with irq_id=0 one edge after the write takes effect.
- Simultaneous set/clear: rise irq_src[2] again in the ack cycle of id 2 → pending[2] remains 1. After ERet, a new REQ with id 2 follows.
- Async reset in SERVICE: drive reset=0 mid-cycle → ExtIRQ=0, irq_active=0, pending=0 before the next clk edge. Stray ExtIAck/ERet in IDLE → no state change.
